instr_encoder: RTL
==================

Name: instr_encoder

Overview:
- Inverse of the pipeline's instruction decode path. Accepts an instruction as a mnemonic index plus operand fields over a valid/ready handshake, and emits the 32-bit MIPS word with its target byte address.
- Output is buffered through a small FIFO. Used by the self-test program loader to fill instruction memory before the 5-stage core is released from reset.
- A seal command appends a terminating self-loop and locks the block.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address given to the first emitted word.
- DEPTH, 2, output FIFO entries (power of two, at least 2).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  instruction offered.
- in_ready  out  1  block can accept this cycle.
- in_mn  in  6  mnemonic index, from the shared package.
- in_rs, in_rt, in_rd, in_shamt  in  5 each  register and shift fields.
- in_imm  in  16  immediate or branch offset.
- in_target  in  26  jump target field.
- in_seal  in  1  seal command; qualified by in_valid, other fields ignored.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer takes the head.
- out_word  out  32  encoded instruction.
- out_addr  out  32  byte address of out_word.
- err_illegal  out  1  one-cycle pulse when an illegal mnemonic is dropped.
- illegal_cnt  out  8  saturating count of dropped words.
- done  out  1  block is sealed.

Behaviour:
- Reset values: in_ready=1, out_valid=0, out_word=0, out_addr=0, err_illegal=0, illegal_cnt=0, done=0. FIFO empty, PC=BASE_ADDR, FSM=RUN.
- Accept: in_valid && in_ready. in_ready = (state==RUN) && !fifo_full. There is no same-cycle bypass when full, even if a pop occurs that cycle.
- Encode is combinational at accept. The word and PC are pushed the same edge, so out_valid rises the cycle after accept (latency 1).
- Word formats:
  - R-type: {6'h00, rs, rt, rd, shamt, func}.
  - SLL/SRL/SRA: rs forced to 0.
  - JR: rt, rd and shamt forced to 0.
  - JALR: rt and shamt forced to 0; rd passed as given.
  - Variable shifts (SLLV/SRLV/SRAV) and other ALU ops: shamt forced to 0.
  - I-type: {op, rs, rt, imm}. LUI forces rs=0. BGTZ/BLEZ force rt=0.
  - REGIMM: {6'h01, rs, code, imm} with code BLTZ=00000, BGEZ=00001, BLTZAL=10000, BGEZAL=10001.
  - J/JAL: {op, target}.
- Illegal mnemonic (index >= 42, or any unassigned index):
  - Still accepted (consumes the handshake); no push, PC unchanged.
  - err_illegal=1 on the following cycle; illegal_cnt increments and saturates at 255.
- PC advances by 4 per pushed word and wraps modulo 2^32.
- FIFO:
  - Pop when out_valid && out_ready.
  - Simultaneous push and pop leaves occupancy unchanged.
  - Pop on empty is impossible (out_valid=0).
  - out_word and out_addr hold stable while out_valid && !out_ready.
- FSM:
  - RUN: an accepted in_seal goes to SEAL.
  - SEAL: in_ready=0. When the FIFO is not full, push 32'h1000FFFF (beq $0,$0,-1) at the current PC, advance PC, go to DONE.
  - DONE: done=1, in_ready=0. Held until rst; the FIFO continues to drain normally.
- Reset mid-operation: FIFO contents discarded, PC reloaded, FSM returns to RUN on the next edge.

Decomposition:
- Shared package instr_enc_pkg:
  - Mnemonic index localparams MN_ADD..MN_BGEZAL, in order: R-type 0–17, I/J 18–37, REGIMM 38–41. MN_W=6.
  - Opcode constants (6-bit), function codes (6-bit), REGIMM rt codes (5-bit).
  - SEAL_WORD constant.
  - The opcode and function values are the same numeric encodings used by the core's decoder, so one package serves both.
- Sub-module enc_fifo: synchronous FIFO, 64-bit entries ({addr, word}), DEPTH entries, push/pop/full/empty, count-based.

Test Plan:
- ADD rd=3 rs=1 rt=2, then ADDI rt=8 rs=0 imm=16'h1234, out_ready=1 → 32'h00221820 @0x0, then 32'h20081234 @0x4, each one cycle after accept.
- SLL rd=2 rt=1 shamt=4 with in_rs=7 → 32'h00011100 (rs cleared). J target=26'h0100000 → 32'h08100000.
- BGEZAL rs=4 imm=16'hFFFF → 32'h0491FFFF.
- Backpressure: out_ready=0, offer 3 legal words → in_ready drops after 2 accepts. Raising out_ready for one cycle re-raises in_ready the next cycle; no loss or reordering.
- in_mn=50 → err_illegal pulses once, illegal_cnt=1, no output, next legal word keeps the un-advanced address.
- Two words then seal → third word 32'h1000FFFF @0x8, done=1. Further in_valid is ignored. rst restores in_ready=1 and addr=BASE_ADDR.

Source files
------------

// File: rtl/instr_enc_pkg.sv
// Shared instruction-set constants and the mnemonic-to-word encoder.
// The decoder in the core uses the same opcode/function values.
package instr_enc_pkg;

  localparam int MN_W = 6;

  localparam logic [MN_W-1:0]
    MN_ADD  = 6'd0,  MN_ADDU = 6'd1,  MN_SUB   = 6'd2,  MN_SUBU  = 6'd3,
    MN_AND  = 6'd4,  MN_OR   = 6'd5,  MN_XOR   = 6'd6,  MN_NOR   = 6'd7,
    MN_SLT  = 6'd8,  MN_SLTU = 6'd9,  MN_SLL   = 6'd10, MN_SRL   = 6'd11,
    MN_SRA  = 6'd12, MN_SLLV = 6'd13, MN_SRLV  = 6'd14, MN_SRAV  = 6'd15,
    MN_JR   = 6'd16, MN_JALR = 6'd17,
    MN_ADDI = 6'd18, MN_ADDIU = 6'd19, MN_SLTI = 6'd20, MN_SLTIU = 6'd21,
    MN_ANDI = 6'd22, MN_ORI  = 6'd23, MN_XORI  = 6'd24, MN_LUI   = 6'd25,
    MN_LB   = 6'd26, MN_LH   = 6'd27, MN_LW    = 6'd28, MN_LBU   = 6'd29,
    MN_SB   = 6'd30, MN_SW   = 6'd31, MN_BEQ   = 6'd32, MN_BNE   = 6'd33,
    MN_BLEZ = 6'd34, MN_BGTZ = 6'd35, MN_J     = 6'd36, MN_JAL   = 6'd37,
    MN_BLTZ = 6'd38, MN_BGEZ = 6'd39, MN_BLTZAL = 6'd40, MN_BGEZAL = 6'd41;

  localparam logic [5:0]
    OP_RTYPE = 6'h00, OP_REGIMM = 6'h01, OP_J = 6'h02, OP_JAL = 6'h03,
    OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_BLEZ = 6'h06, OP_BGTZ = 6'h07,
    OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B,
    OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_XORI = 6'h0E, OP_LUI = 6'h0F,
    OP_LB = 6'h20, OP_LH = 6'h21, OP_LW = 6'h23, OP_LBU = 6'h24,
    OP_SB = 6'h28, OP_SW = 6'h2B;

  localparam logic [5:0]
    FN_SLL = 6'h00, FN_SRL = 6'h02, FN_SRA = 6'h03, FN_SLLV = 6'h04,
    FN_SRLV = 6'h06, FN_SRAV = 6'h07, FN_JR = 6'h08, FN_JALR = 6'h09,
    FN_ADD = 6'h20, FN_ADDU = 6'h21, FN_SUB = 6'h22, FN_SUBU = 6'h23,
    FN_AND = 6'h24, FN_OR = 6'h25, FN_XOR = 6'h26, FN_NOR = 6'h27,
    FN_SLT = 6'h2A, FN_SLTU = 6'h2B;

  localparam logic [4:0]
    RT_BLTZ = 5'b00000, RT_BGEZ = 5'b00001, RT_BLTZAL = 5'b10000, RT_BGEZAL = 5'b10001;

  // beq $0,$0,-1: the loaded program parks here forever.
  localparam logic [31:0] SEAL_WORD = 32'h1000_FFFF;

  typedef enum logic [1:0] {ST_RUN, ST_SEAL, ST_DONE} state_t;

  typedef struct packed {
    logic        legal;
    logic [31:0] word;
  } enc_t;

  function automatic enc_t encode(
    input logic [MN_W-1:0] mn,
    input logic [4:0]      rs,
    input logic [4:0]      rt,
    input logic [4:0]      rd,
    input logic [4:0]      shamt,
    input logic [15:0]     imm,
    input logic [25:0]     target
  );
    enc_t       e;
    logic [5:0] code;
    logic [4:0] rcode;
    e.legal = 1'b1;
    e.word  = 32'h0;
    code    = 6'h00;
    rcode   = 5'h00;
    case (mn)
      MN_ADD:   code = FN_ADD;   MN_ADDU:  code = FN_ADDU;  MN_SUB:   code = FN_SUB;
      MN_SUBU:  code = FN_SUBU;  MN_AND:   code = FN_AND;   MN_OR:    code = FN_OR;
      MN_XOR:   code = FN_XOR;   MN_NOR:   code = FN_NOR;   MN_SLT:   code = FN_SLT;
      MN_SLTU:  code = FN_SLTU;  MN_SLL:   code = FN_SLL;   MN_SRL:   code = FN_SRL;
      MN_SRA:   code = FN_SRA;   MN_SLLV:  code = FN_SLLV;  MN_SRLV:  code = FN_SRLV;
      MN_SRAV:  code = FN_SRAV;  MN_JR:    code = FN_JR;    MN_JALR:  code = FN_JALR;
      MN_ADDI:  code = OP_ADDI;  MN_ADDIU: code = OP_ADDIU; MN_SLTI:  code = OP_SLTI;
      MN_SLTIU: code = OP_SLTIU; MN_ANDI:  code = OP_ANDI;  MN_ORI:   code = OP_ORI;
      MN_XORI:  code = OP_XORI;  MN_LUI:   code = OP_LUI;   MN_LB:    code = OP_LB;
      MN_LH:    code = OP_LH;    MN_LW:    code = OP_LW;    MN_LBU:   code = OP_LBU;
      MN_SB:    code = OP_SB;    MN_SW:    code = OP_SW;    MN_BEQ:   code = OP_BEQ;
      MN_BNE:   code = OP_BNE;   MN_BLEZ:  code = OP_BLEZ;  MN_BGTZ:  code = OP_BGTZ;
      MN_J:     code = OP_J;     MN_JAL:   code = OP_JAL;
      MN_BLTZ:  rcode = RT_BLTZ;   MN_BGEZ:   rcode = RT_BGEZ;
      MN_BLTZAL: rcode = RT_BLTZAL; MN_BGEZAL: rcode = RT_BGEZAL;
      default:  e.legal = 1'b0;
    endcase
    if (mn <= MN_JALR) begin
      case (mn)
        MN_SLL, MN_SRL, MN_SRA: e.word = {OP_RTYPE, 5'd0, rt, rd, shamt, code};
        MN_JR:                  e.word = {OP_RTYPE, rs, 15'd0, code};
        MN_JALR:                e.word = {OP_RTYPE, rs, 5'd0, rd, 5'd0, code};
        default:                e.word = {OP_RTYPE, rs, rt, rd, 5'd0, code};
      endcase
    end else if (mn <= MN_BGTZ) begin
      case (mn)
        MN_LUI:           e.word = {code, 5'd0, rt, imm};
        MN_BLEZ, MN_BGTZ: e.word = {code, rs, 5'd0, imm};
        default:          e.word = {code, rs, rt, imm};
      endcase
    end else if (mn <= MN_JAL) begin
      e.word = {code, target};
    end else if (mn <= MN_BGEZAL) begin
      e.word = {OP_REGIMM, rs, rcode, imm};
    end
    return e;
  endfunction

endpackage

// File: rtl/instr_encoder_fifo.sv
// Count-based synchronous FIFO holding {addr, word} pairs for the encoder.
// head reads as zero while the FIFO is empty.
module enc_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = empty ? '0 : mem[rd_ptr];

  // NOTE: storage is deliberately not reset; count gates every read, so stale entries are never seen.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= data;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// Encodes mnemonic+operand requests into MIPS words with byte addresses,
// buffered through a small FIFO; a seal command appends a self-loop and locks.
module instr_encoder
  import instr_enc_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [MN_W-1:0] in_mn,
  input  logic [4:0]      in_rs,
  input  logic [4:0]      in_rt,
  input  logic [4:0]      in_rd,
  input  logic [4:0]      in_shamt,
  input  logic [15:0]     in_imm,
  input  logic [25:0]     in_target,
  input  logic            in_seal,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_word,
  output logic [31:0]     out_addr,
  output logic            err_illegal,
  output logic [7:0]      illegal_cnt,
  output logic            done
);

  state_t      state;
  logic [31:0] pc;
  enc_t        enc;
  logic        accept;
  logic        push;
  logic        pop;
  logic        full;
  logic        empty;
  logic [63:0] push_data;
  logic [63:0] head;

  assign enc       = encode(in_mn, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target);
  assign in_ready  = (state == ST_RUN) && !full;
  assign accept    = in_valid && in_ready;
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  assign {out_addr, out_word} = head;
  assign done      = (state == ST_DONE);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    push      = 1'b0;
    push_data = {pc, enc.word};
    if (state == ST_RUN) begin
      push = accept && !in_seal && enc.legal;
    end else if (state == ST_SEAL) begin
      push      = !full;
      push_data = {pc, SEAL_WORD};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_RUN;
      pc          <= BASE_ADDR;
      err_illegal <= 1'b0;
      illegal_cnt <= 8'd0;
    end else begin
      err_illegal <= 1'b0;
      if (push) pc <= pc + 32'd4;
      case (state)
        ST_RUN: begin
          if (accept) begin
            if (in_seal) begin
              state <= ST_SEAL;
            end else if (!enc.legal) begin
              // Illegal words consume the handshake but never reach the FIFO.
              err_illegal <= 1'b1;
              if (illegal_cnt != 8'hFF) illegal_cnt <= illegal_cnt + 8'd1;
            end
          end
        end
        ST_SEAL: if (!full) state <= ST_DONE;
        default: ;
      endcase
    end
  end

  enc_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(64)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .data (push_data),
    .head (head),
    .full (full),
    .empty(empty)
  );

endmodule
